// File: rtl/reset_sequencer.sv
// Lock-qualified reset sequencer: waits for stable PLL lock, then releases sys/adc/eth resets in staggered order.
// Status inputs pass through 2-flop synchronizers; any lock loss or software request re-asserts all resets.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 256,
  parameter int LOCK_TIMEOUT       = 1000000
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clocks_valid,
  input  logic       sw_reset_req,
  output logic       rst_sys_n,
  output logic       rst_adc_n,
  output logic       rst_eth_n,
  output logic       system_ready,
  output logic       lock_timeout,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam int MAX_CNT = (LOCK_STABLE_CYCLES > STAGE_DELAY) ? LOCK_STABLE_CYCLES : STAGE_DELAY;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int TMR_W   = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    REL_SYS   = 3'd2,
    REL_ADC   = 3'd3,
    REL_ETH   = 3'd4,
    RUN       = 3'd5
  } seq_state_t;

  seq_state_t       state_q, state_d;
  logic [1:0]       pll_sync, clk_sync;
  logic             lock_ok;
  logic [CNT_W-1:0] cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic             abort, loss_evt, cnt_clr;
  logic             sys_d, adc_d, eth_d, rdy_d;

  assign lock_ok = pll_sync[1] & clk_sync[1];
  assign abort   = ~lock_ok | sw_reset_req;
  assign state   = state_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pll_sync <= 2'b00;
      clk_sync <= 2'b00;
    end else begin
      pll_sync <= {pll_sync[0], pll_locked};
      clk_sync <= {clk_sync[0], clocks_valid};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    loss_evt = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = STABLE;
          cnt_clr = 1'b1;
        end
      end
      STABLE: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          cnt_clr = 1'b1;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = REL_SYS;
          cnt_clr = 1'b1;
        end
      end
      REL_SYS, REL_ADC, REL_ETH: begin
        loss_evt = ~lock_ok;
        if (abort) begin
          state_d = WAIT_LOCK;
          cnt_clr = 1'b1;
        end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
          cnt_clr = 1'b1;
          case (state_q)
            REL_SYS: state_d = REL_ADC;
            REL_ADC: state_d = REL_ETH;
            default: state_d = RUN;
          endcase
        end
      end
      RUN: begin
        loss_evt = ~lock_ok;
        if (abort) begin
          state_d = WAIT_LOCK;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_clr = 1'b1;
      end
    endcase
    // Outputs are a registered decode of the next state, so each release lands on its transition edge.
    sys_d = (state_d == REL_SYS) || (state_d == REL_ADC) || (state_d == REL_ETH) || (state_d == RUN);
    adc_d = (state_d == REL_ADC) || (state_d == REL_ETH) || (state_d == RUN);
    eth_d = (state_d == REL_ETH) || (state_d == RUN);
    rdy_d = (state_d == RUN);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q         <= WAIT_LOCK;
      cnt_q           <= '0;
      rst_sys_n       <= 1'b0;
      rst_adc_n       <= 1'b0;
      rst_eth_n       <= 1'b0;
      system_ready    <= 1'b0;
      lock_loss_count <= 8'd0;
    end else begin
      state_q      <= state_d;
      rst_sys_n    <= sys_d;
      rst_adc_n    <= adc_d;
      rst_eth_n    <= eth_d;
      system_ready <= rdy_d;
      if (cnt_clr)
        cnt_q <= '0;
      else if (state_q != WAIT_LOCK)
        cnt_q <= cnt_q + 1'b1;
      if (loss_evt && lock_loss_count != 8'd255)
        lock_loss_count <= lock_loss_count + 8'd1;
    end
  end

  // Timeout timer runs only while waiting for lock and saturates at the limit; the flag stays set until rst.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      tmr_q        <= '0;
      lock_timeout <= 1'b0;
    end else if (state_q == WAIT_LOCK) begin
      if (tmr_q != TMR_W'(LOCK_TIMEOUT))
        tmr_q <= tmr_q + 1'b1;
      if (tmr_q >= TMR_W'(LOCK_TIMEOUT - 1))
        lock_timeout <= 1'b1;
    end else begin
      tmr_q <= '0;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with L=16, S=8, timeout=100; expected edge numbers are hand-derived.
module tb_reset_sequencer;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       pll_locked, clocks_valid, sw_reset_req;
  logic       rst_sys_n, rst_adc_n, rst_eth_n, system_ready, lock_timeout;
  logic [7:0] lock_loss_count;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_loss;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(16),
    .STAGE_DELAY       (8),
    .LOCK_TIMEOUT      (100)
  ) dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .clocks_valid   (clocks_valid),
    .sw_reset_req   (sw_reset_req),
    .rst_sys_n      (rst_sys_n),
    .rst_adc_n      (rst_adc_n),
    .rst_eth_n      (rst_eth_n),
    .system_ready   (system_ready),
    .lock_timeout   (lock_timeout),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic outs_low(input string tag);
    check({tag, "_sys"}, {31'd0, rst_sys_n}, 0);
    check({tag, "_adc"}, {31'd0, rst_adc_n}, 0);
    check({tag, "_eth"}, {31'd0, rst_eth_n}, 0);
    check({tag, "_rdy"}, {31'd0, system_ready}, 0);
  endtask

  // d = edges from now until STABLE is entered; then releases follow at +16, +24, +32, +40.
  task automatic seq_check(input string tag, input int d);
    tick(d - 1);
    check({tag, "_pre_state"}, {29'd0, state}, 0);
    tick(1);
    check({tag, "_stable"}, {29'd0, state}, 1);
    tick(15);
    check({tag, "_sys_lo"}, {31'd0, rst_sys_n}, 0);
    tick(1);
    check({tag, "_sys_hi"}, {31'd0, rst_sys_n}, 1);
    check({tag, "_st2"}, {29'd0, state}, 2);
    tick(7);
    check({tag, "_adc_lo"}, {31'd0, rst_adc_n}, 0);
    tick(1);
    check({tag, "_adc_hi"}, {31'd0, rst_adc_n}, 1);
    check({tag, "_st3"}, {29'd0, state}, 3);
    tick(7);
    check({tag, "_eth_lo"}, {31'd0, rst_eth_n}, 0);
    tick(1);
    check({tag, "_eth_hi"}, {31'd0, rst_eth_n}, 1);
    check({tag, "_st4"}, {29'd0, state}, 4);
    tick(7);
    check({tag, "_rdy_lo"}, {31'd0, system_ready}, 0);
    tick(1);
    check({tag, "_rdy_hi"}, {31'd0, system_ready}, 1);
    check({tag, "_st5"}, {29'd0, state}, 5);
  endtask

  initial begin
    rst          = 1'b1;
    pll_locked   = 1'b0;
    clocks_valid = 1'b0;
    sw_reset_req = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    outs_low("rst");
    check("rst_state", {29'd0, state}, 0);
    check("rst_loss", {24'd0, lock_loss_count}, 0);
    check("rst_tmo", {31'd0, lock_timeout}, 0);
    rst = 1'b0;

    // Timeout with lock held low.
    tick(99);
    check("tmo_99", {31'd0, lock_timeout}, 0);
    tick(1);
    check("tmo_100", {31'd0, lock_timeout}, 1);
    tick(20);
    check("tmo_wait_state", {29'd0, state}, 0);
    outs_low("tmo_wait");

    // Late lock: full sequence, timeout flag stays set.
    pll_locked   = 1'b1;
    clocks_valid = 1'b1;
    seq_check("pwr", 3);
    check("pwr_tmo_sticky", {31'd0, lock_timeout}, 1);
    check("pwr_loss", {24'd0, lock_loss_count}, 0);

    // Lock loss in RUN: outputs drop on the third edge.
    pll_locked = 1'b0;
    tick(2);
    check("ll_st_hold", {29'd0, state}, 5);
    check("ll_sys_hold", {31'd0, rst_sys_n}, 1);
    tick(1);
    check("ll_state", {29'd0, state}, 0);
    outs_low("ll");
    check("ll_count", {24'd0, lock_loss_count}, 1);
    tick(5);

    // Glitch during STABLE: no count, full 16-cycle restart.
    pll_locked = 1'b1;
    tick(5);
    check("gl_stable", {29'd0, state}, 1);
    pll_locked = 1'b0;
    tick(3);
    check("gl_abort", {29'd0, state}, 0);
    check("gl_count", {24'd0, lock_loss_count}, 1);
    pll_locked = 1'b1;
    seq_check("gl", 3);
    check("gl_count_end", {24'd0, lock_loss_count}, 1);

    // Software request in RUN, then again in REL_ADC.
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    check("sw1_state", {29'd0, state}, 0);
    outs_low("sw1");
    tick(1);
    check("sw1_stable", {29'd0, state}, 1);
    tick(24);
    check("sw1_reladc", {29'd0, state}, 3);
    tick(3);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    check("sw2_state", {29'd0, state}, 0);
    outs_low("sw2");
    check("sw2_count", {24'd0, lock_loss_count}, 1);
    seq_check("sw2", 1);
    check("sw2_count_end", {24'd0, lock_loss_count}, 1);

    // 300 lock losses from RUN saturate the counter.
    exp_loss = 1;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(3);
      if (exp_loss < 255) exp_loss++;
      if (i == 0) check("sat_first", {24'd0, lock_loss_count}, exp_loss);
      pll_locked = 1'b1;
      tick(43);
    end
    check("sat_state", {29'd0, state}, 5);
    check("sat_count", {24'd0, lock_loss_count}, 255);

    // Asynchronous rst during REL_ETH.
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    tick(33);
    check("ar_releth", {29'd0, state}, 4);
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    outs_low("ar");
    check("ar_state", {29'd0, state}, 0);
    check("ar_loss", {24'd0, lock_loss_count}, 0);
    check("ar_tmo", {31'd0, lock_timeout}, 0);
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    tick(1);
    check("ar_post_state", {29'd0, state}, 0);
    outs_low("ar_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-on and lock-loss reset sequencer fed by the clock manager's `pll_locked` and `clocks_valid` status. It waits for stable lock, then releases per-domain active-low resets in fixed order (system, ADC, Ethernet) with programmable stagger, and asserts `system_ready`. It re-asserts all domain resets on lock loss or software request, and reports lock timeout and lock-loss statistics.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive locked cycles required before the first release.
- `STAGE_DELAY`, 256: cycles between successive releases.
- `LOCK_TIMEOUT`, 1000000: cycles in WAIT_LOCK before `lock_timeout` sets.

Ports:
- `clk_sys`  in  1  system clock; sole clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  asynchronous lock status; 2-flop synchronized.
- `clocks_valid`  in  1  asynchronous clocks-valid status; 2-flop synchronized.
- `sw_reset_req`  in  1  synchronous request pulse; re-sequence all domains.
- `rst_sys_n`  out  1  system-domain reset, active low.
- `rst_adc_n`  out  1  ADC-domain reset, active low.
- `rst_eth_n`  out  1  Ethernet-domain reset, active low.
- `system_ready`  out  1  all domains released.
- `lock_timeout`  out  1  sticky: lock not seen within `LOCK_TIMEOUT`.
- `lock_loss_count`  out  8  lock-loss events after first release; saturates at 255.
- `state`  out  3  current FSM state encoding.

## Operation
- `lock_ok` = synchronized `pll_locked` AND synchronized `clocks_valid`.
- States: WAIT_LOCK=0, STABLE=1, REL_SYS=2, REL_ADC=3, REL_ETH=4, RUN=5. Codes 6 and 7 are unreachable; if entered, go to WAIT_LOCK.
- WAIT_LOCK: all resets asserted and `system_ready`=0. On `lock_ok`=1, go to STABLE with the counter cleared.
- STABLE: counter increments each cycle. At count `LOCK_STABLE_CYCLES`-1, go to REL_SYS.
- REL_SYS, REL_ADC, REL_ETH: each lasts `STAGE_DELAY` cycles, then advances. RUN is terminal.
- Registered outputs update on the transition edge:
  - `rst_sys_n`=1 on entry to REL_SYS.
  - `rst_adc_n`=1 on entry to REL_ADC.
  - `rst_eth_n`=1 on entry to REL_ETH.
  - `system_ready`=1 on entry to RUN.
- Abort: `lock_ok`=0 or `sw_reset_req`=1 in any state other than WAIT_LOCK causes, on the next edge:
  - state goes to WAIT_LOCK;
  - all `rst_*_n`=0 and `system_ready`=0 simultaneously;
  - counters are cleared.
- `lock_loss_count` increments only when the abort is caused by `lock_ok`=0 while in REL_SYS through RUN. A lock drop during STABLE does not count. If lock loss and `sw_reset_req` occur in the same cycle, the event counts once. `sw_reset_req` alone never counts.
- `sw_reset_req` in WAIT_LOCK: no effect.
- Timeout timer: counts only in WAIT_LOCK and clears on entry to WAIT_LOCK. It sets `lock_timeout` after `LOCK_TIMEOUT` cycles. The flag is sticky until `rst`; timer saturates. Sequencing still proceeds if lock arrives later.
- Counter widths: `$clog2` of the largest value each must hold. No wrap on any counter.

## Timing
- Reset values:
  - all `rst_*_n`=0, `system_ready`=0;
  - `lock_timeout`=0, `lock_loss_count`=0;
  - `state`=0, synchronizer flops 0.
- Input latency: 2 cycles from the status inputs to `lock_ok`. The FSM reacts on the following edge.
- Reference edge: inputs sampled high first at edge E0. Then:
  - E2: STABLE
  - E2+L: `rst_sys_n`=1
  - E2+L+S: `rst_adc_n`=1
  - E2+L+2S: `rst_eth_n`=1
  - E2+L+3S: `system_ready`=1
  - L=`LOCK_STABLE_CYCLES`, S=`STAGE_DELAY`.
- Abort latency: all outputs low 3 edges after the lock input falls (2 sync + 1), or 1 edge after `sw_reset_req`.
- `rst` asserted mid-sequence: all outputs return to reset values immediately and asynchronously.
- Release of `rst`: synchronous to `clk_sys`.

## Test plan
- Power-up, L=16, S=8, both inputs high from E0 → releases at E18, E26, E34; `system_ready` at E42; `lock_loss_count`=0.
- Lock glitch of 3 cycles during STABLE → back to WAIT_LOCK, STABLE restarts with the full 16-cycle count, `lock_loss_count` stays 0.
- Drop `pll_locked` in RUN → all resets low 3 edges later, `lock_loss_count`=1, full sequence repeats when lock returns. Repeat 300 times → count saturates at 255.
- `sw_reset_req` pulse in REL_ADC → next edge: `state`=0, all resets low, count unchanged; re-sequence completes normally.
- `LOCK_TIMEOUT`=100 with lock held low → `lock_timeout`=1 after 100 cycles in WAIT_LOCK. Lock later → sequence completes with `lock_timeout` still 1.
- `rst` asserted during REL_ETH → all outputs 0 immediately; after release, `state`=0.
